// File: rtl/sr_seq_checker.sv
// sr_seq_checker: drives a fixed S/R stimulus table into an external SR latch,
// holds each step for HOLD cycles, and checks the latch outputs on the last
// hold cycle of every step against a simple known/unknown model.
module sr_seq_checker #(
  parameter int HOLD = 4  // cycles per step, legal 2..15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       q_in,
  input  logic       qbar_in,
  output logic       s_out,
  output logic       r_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [3:0] step
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_M1   = 4'(HOLD - 1);
  localparam logic [3:0] LAST_STEP = 4'd9;
  localparam logic [3:0] ERR_MAX   = 4'd15;

  // Fixed stimulus table, value is {S,R}.
  function automatic logic [1:0] step_sr(input logic [3:0] idx);
    case (idx)
      4'd0:    step_sr = 2'b10;
      4'd2:    step_sr = 2'b01;
      4'd5:    step_sr = 2'b11;
      4'd9:    step_sr = 2'b10;
      default: step_sr = 2'b00;
    endcase
  endfunction

  state_t     r_state, w_state_nxt;
  logic [3:0] r_hold,  w_hold_nxt;
  logic [3:0] r_step,  w_step_nxt;
  logic [1:0] r_sr,    w_sr_nxt;
  logic [3:0] r_err,   w_err_nxt;
  logic       r_known, w_known_nxt;
  logic [1:0] r_exp,   w_exp_nxt;

  logic [1:0] w_cur_sr;
  logic       w_chk_en;
  logic [1:0] w_chk_exp;
  logic       w_known_upd;
  logic [1:0] w_exp_upd;
  logic       w_mismatch;
  logic       w_last_hold;

  assign w_last_hold = (r_hold == HOLD_M1);

  // Expected-pair model for the step currently driven.
  always_comb begin
    w_cur_sr    = step_sr(r_step);
    w_chk_en    = 1'b0;
    w_chk_exp   = 2'b00;
    w_known_upd = r_known;
    w_exp_upd   = r_exp;
    case (w_cur_sr)
      2'b10: begin
        w_chk_en    = 1'b1;
        w_chk_exp   = 2'b10;
        w_known_upd = 1'b1;
        w_exp_upd   = 2'b10;
      end
      2'b01: begin
        w_chk_en    = 1'b1;
        w_chk_exp   = 2'b01;
        w_known_upd = 1'b1;
        w_exp_upd   = 2'b01;
      end
      2'b11: begin
        // Both inputs set: NOR latch drives 00, and what it settles to after
        // release is a race, so the model forgets its state.
        w_chk_en    = 1'b1;
        w_chk_exp   = 2'b00;
        w_known_upd = 1'b0;
        w_exp_upd   = 2'b00;
      end
      default: begin
        // Hold: expect the previous pair only if it is known.
        w_chk_en  = r_known;
        w_chk_exp = r_exp;
      end
    endcase
    w_mismatch = w_chk_en && ({q_in, qbar_in} != w_chk_exp);
  end

  // Next-state and datapath updates for the sequencer FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_step_nxt  = r_step;
    w_sr_nxt    = r_sr;
    w_err_nxt   = r_err;
    w_known_nxt = r_known;
    w_exp_nxt   = r_exp;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_nxt = ST_DRIVE;
          w_hold_nxt  = 4'd0;
          w_step_nxt  = 4'd0;
          w_sr_nxt    = step_sr(4'd0);
          w_err_nxt   = 4'd0;
          w_known_nxt = 1'b0;
          w_exp_nxt   = 2'b00;
        end
      end
      ST_DRIVE: begin
        if (w_last_hold) begin
          if (w_mismatch && (r_err != ERR_MAX))
            w_err_nxt = r_err + 4'd1;
          w_known_nxt = w_known_upd;
          w_exp_nxt   = w_exp_upd;
          w_hold_nxt  = 4'd0;
          if (r_step == LAST_STEP) begin
            w_state_nxt = ST_DONE;
            w_step_nxt  = 4'd0;
            w_sr_nxt    = 2'b00;
          end else begin
            w_step_nxt = r_step + 4'd1;
            w_sr_nxt   = step_sr(r_step + 4'd1);
          end
        end else begin
          w_hold_nxt = r_hold + 4'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_hold_nxt  = 4'd0;
        w_step_nxt  = 4'd0;
        w_sr_nxt    = 2'b00;
      end
    endcase
  end

  // State register; reset wins over any start on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_hold  <= 4'd0;
      r_step  <= 4'd0;
      r_sr    <= 2'b00;
      r_err   <= 4'd0;
      r_known <= 1'b0;
      r_exp   <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
      r_step  <= w_step_nxt;
      r_sr    <= w_sr_nxt;
      r_err   <= w_err_nxt;
      r_known <= w_known_nxt;
      r_exp   <= w_exp_nxt;
    end
  end

  assign s_out     = r_sr[1];
  assign r_out     = r_sr[0];
  assign busy      = (r_state == ST_DRIVE);
  assign done      = (r_state == ST_DONE);
  assign pass      = (r_state == ST_DONE) && (r_err == 4'd0);
  assign err_count = r_err;
  assign step      = r_step;

endmodule

// File: doc/sr_seq_checker.md
SR_SEQ_CHECKER -- requirements
Module: sr_seq_checker

Interface
- REQ-001: The module SHALL have parameter HOLD, default 4, giving the number of clock cycles each stimulus step is held (legal range 2..15).
- REQ-002: clk  input  1  single clock; all logic updates on its rising edge.
- REQ-003: rst  input  1  reset; synchronous and active-high.
- REQ-004: start  input  1  a high level sampled in IDLE or DONE launches the stimulus sequence.
- REQ-005: q_in  input  1  Q output of the SR latch under test.
- REQ-006: qbar_in  input  1  Qbar output of the SR latch under test.
- REQ-007: s_out  output  1  S drive to the latch, registered.
- REQ-008: r_out  output  1  R drive to the latch, registered.
- REQ-009: busy  output  1  high while the sequence is being driven.
- REQ-010: done  output  1  high in DONE until the next start or reset.
- REQ-011: pass  output  1  valid while done is high; 1 when err_count is 0.
- REQ-012: err_count  output  4  number of mismatching checks; saturates at 15.
- REQ-013: step  output  4  index of the step being driven (0..9); 0 when not busy.

Function
- REQ-014: The FSM SHALL have states IDLE, DRIVE and DONE, and reset to IDLE.
- REQ-015: Transitions SHALL be: IDLE->DRIVE on start; DRIVE->DONE after the last cycle of step 9; DONE->DRIVE on start; no other transitions except reset.
- REQ-016: The fixed step table {S,R} SHALL be: 0:10, 1:00, 2:01, 3:00, 4:00, 5:11, 6:00, 7:00, 8:00, 9:10.
- REQ-017: On entry to DRIVE, s_out/r_out SHALL take the step-0 value on the same edge that sets busy, with step=0 and err_count cleared to 0.
- REQ-018: Each step SHALL last exactly HOLD cycles, counted by a hold counter that restarts at 0 on every new step; total DRIVE time is 10*HOLD cycles.
- REQ-019: On the last hold cycle of a step, the module SHALL compare {q_in,qbar_in} with the expected pair, then advance step and drive the next table value.
- REQ-020: Expected-model rules: 10 -> expect 10, model known; 01 -> expect 01, model known; 11 -> expect 00, model becomes unknown; 00 -> expect the previous expected pair if known, else skip the check.
- REQ-021: The model SHALL start unknown on every sequence launch.
- REQ-022: A check SHALL increment err_count by 1 on mismatch, holding at 15 once reached; a skipped check SHALL leave err_count unchanged.
- REQ-023: In the checked steps of the fixed table, steps 6, 7 and 8 SHALL be skipped; all other steps SHALL be checked.
- REQ-024: In IDLE and DONE, s_out=0, r_out=0, busy=0 and step=0.
- REQ-025: DONE SHALL assert done=1 and pass=(err_count==0); err_count SHALL hold its final value.
- REQ-026: start while busy SHALL be ignored.
- REQ-027: start held high continuously SHALL relaunch immediately: DONE lasts exactly 1 cycle.
- REQ-028: q_in and qbar_in SHALL be used only on check cycles and SHALL have no effect on any other cycle.

Reset
- REQ-029: When rst=1 at a clock edge, outputs SHALL become: s_out=0, r_out=0, busy=0, done=0, pass=0, err_count=0, step=0; the FSM goes to IDLE, the hold counter to 0 and the model to unknown.
- REQ-030: Reset mid-DRIVE SHALL abort the sequence with no partial done, and rst SHALL take priority over start on the same edge.

Verification
- REQ-031: Connect a correct NOR SR latch, HOLD=4, pulse start -> busy for 40 cycles, s/r follow the table, then done=1, pass=1, err_count=0.
- REQ-032: Tie q_in=0, qbar_in=1 -> checks at steps 0, 1, 5 and 9 mismatch (step 2-4 match) -> err_count=4... recomputed per model: steps 0,1,5,9 fail and step 5 expects 00 -> err_count=4, pass=0.
- REQ-033: Assert rst at cycle 13 of DRIVE -> on the next edge all outputs are 0 and the state is IDLE; a new start runs the full 40 cycles again.
- REQ-034: Pulse start during DRIVE -> no change in step, hold timing or err_count.
- REQ-035: Use HOLD=2, hold start high, correct latch -> DRIVE 20 cycles, done=1 for 1 cycle, DRIVE restarts with err_count=0.
- REQ-036: Force q_in=qbar_in=1 throughout -> every checked step mismatches (7 checks) -> err_count=7, pass=0; steps 6-8 are not counted.
